// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer: stall vector, multi-cycle EX sequencing, exception flush
module pipe_ctrl #(
    parameter int MC_CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_mem,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    input  logic                exc_valid,
    input  logic [31:0]         exc_handler,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                mc_busy,
    output logic                mc_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MC_RUN = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam logic [5:0]          STALL_MEM = 6'b011111;
    localparam logic [5:0]          STALL_EX  = 6'b001111;
    localparam logic [5:0]          STALL_ID  = 6'b000111;
    localparam logic [MC_CNT_W-1:0] CNT_ONE   = MC_CNT_W'(1);

    state_t              state;
    logic [MC_CNT_W-1:0] cnt;
    logic                ex_req;

    // Outputs are forced quiet while reset is held so nothing leaks from live request lines.
    always_comb begin
        ex_req  = 1'b0;
        mc_busy = 1'b0;
        mc_done = 1'b0;
        stall   = 6'b000000;
        if (!rst) begin
            case (state)
                IDLE: ex_req = mc_start;
                MC_RUN: begin
                    mc_busy = 1'b1;
                    ex_req  = (cnt > CNT_ONE);
                    mc_done = (cnt == CNT_ONE);
                end
                default: ex_req = 1'b0;
            endcase
            if (state != FLUSH) begin
                if (stallreq_mem)
                    stall = STALL_MEM;
                else if (ex_req)
                    stall = STALL_EX;
                else if (stallreq_id)
                    stall = STALL_ID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            flush  <= 1'b0;
            new_pc <= 32'h0;
        end else if (exc_valid) begin
            // An exception drops any pending start and aborts a running op without mc_done.
            state  <= FLUSH;
            cnt    <= '0;
            flush  <= 1'b1;
            new_pc <= exc_handler;
        end else begin
            flush <= 1'b0;
            case (state)
                IDLE: begin
                    if (mc_start) begin
                        cnt   <= (mc_cycles == '0) ? CNT_ONE : mc_cycles;
                        state <= MC_RUN;
                    end
                end
                MC_RUN: begin
                    if (!stallreq_mem) begin
                        if (cnt > CNT_ONE) begin
                            cnt <= cnt - CNT_ONE;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_mem;
    logic        mc_start;
    logic [5:0]  mc_cycles;
    logic        exc_valid;
    logic [31:0] exc_handler;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        mc_done;

    int checks = 0;
    int errors = 0;

    // model state: cycles left until the op result is valid (0 = no op), pending flush
    int          m_left = 0;
    bit          m_flush = 1'b0;
    logic [31:0] m_pc = 32'h0;

    // values sampled by the last cycle() call
    logic [5:0]  s_stall;
    logic        s_flush;
    logic [31:0] s_pc;
    logic        s_busy;
    logic        s_done;

    pipe_ctrl #(.MC_CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .exc_valid    (exc_valid),
        .exc_handler  (exc_handler),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [5:0] e_stall;
        logic       e_busy, e_done, ex;
        @(negedge clk);
        s_stall = stall; s_flush = flush; s_pc = new_pc; s_busy = mc_busy; s_done = mc_done;
        e_stall = 6'b000000; e_busy = 1'b0; e_done = 1'b0;
        if (!rst && !m_flush) begin
            e_busy = (m_left > 0);
            e_done = (m_left == 1);
            ex     = e_busy ? (m_left > 1) : mc_start;
            if (stallreq_mem)     e_stall = 6'b011111;
            else if (ex)          e_stall = 6'b001111;
            else if (stallreq_id) e_stall = 6'b000111;
        end
        chk("stall", {26'h0, stall}, {26'h0, e_stall});
        chk("flush", {31'h0, flush}, {31'h0, m_flush});
        chk("mc_busy", {31'h0, mc_busy}, {31'h0, e_busy});
        chk("mc_done", {31'h0, mc_done}, {31'h0, e_done});
        if (m_flush || rst) chk("new_pc", new_pc, m_pc);
        if (rst) begin
            m_flush = 1'b0; m_pc = 32'h0; m_left = 0;
        end else if (exc_valid) begin
            m_flush = 1'b1; m_pc = exc_handler; m_left = 0;
        end else if (m_flush) begin
            m_flush = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            if (!stallreq_mem) m_left = m_left - 1;
        end else if (mc_start) begin
            m_left = (mc_cycles == 0) ? 1 : int'(mc_cycles);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stallreq_id = 1'b0; stallreq_mem = 1'b0; mc_start = 1'b0;
        mc_cycles = 6'd0; exc_valid = 1'b0; exc_handler = 32'h0;
    endtask

    initial begin
        int seen_done;
        idle_inputs();
        rst = 1'b1; stallreq_id = 1'b1; stallreq_mem = 1'b1; mc_start = 1'b1;
        mc_cycles = 6'd5; exc_valid = 1'b1; exc_handler = 32'hdeadbeef;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_stall", {26'h0, s_stall}, 32'h0);
            chk("rst_flush_pc", {s_flush, s_pc[30:0]}, 32'h0);
            chk("rst_busy_done", {30'h0, s_busy, s_done}, 32'h0);
        end
        idle_inputs();
        cycle();

        // priority
        stallreq_id = 1'b1;  cycle(); chk("prio_id", {26'h0, s_stall}, 32'h07);
        stallreq_mem = 1'b1; cycle(); chk("prio_mem", {26'h0, s_stall}, 32'h1f);
        stallreq_id = 1'b0; stallreq_mem = 1'b0; cycle(); chk("prio_none", {26'h0, s_stall}, 32'h00);

        // four-cycle op: stall T..T+3, done at T+4
        mc_start = 1'b1; mc_cycles = 6'd4;
        for (int k = 0; k <= 5; k++) begin
            cycle();
            mc_start = 1'b0;
            chk("mc4_stall", {26'h0, s_stall}, (k <= 3) ? 32'h0f : 32'h00);
            chk("mc4_done", {31'h0, s_done}, (k == 4) ? 32'h1 : 32'h0);
            chk("mc4_busy", {31'h0, s_busy}, (k >= 1 && k <= 4) ? 32'h1 : 32'h0);
        end

        // zero length behaves as one
        mc_start = 1'b1; mc_cycles = 6'd0;
        for (int k = 0; k <= 2; k++) begin
            cycle();
            mc_start = 1'b0;
            chk("mc0_stall", {26'h0, s_stall}, (k == 0) ? 32'h0f : 32'h00);
            chk("mc0_done", {31'h0, s_done}, (k == 1) ? 32'h1 : 32'h0);
        end

        // memory stall at T+2,T+3 pushes done from T+3 to T+5
        mc_start = 1'b1; mc_cycles = 6'd3;
        for (int k = 0; k <= 6; k++) begin
            stallreq_mem = (k == 2 || k == 3);
            cycle();
            mc_start = 1'b0;
            if (k == 2 || k == 3) chk("mem_stall", {26'h0, s_stall}, 32'h1f);
            chk("mem_done", {31'h0, s_done}, (k == 5) ? 32'h1 : 32'h0);
        end
        stallreq_mem = 1'b0;

        // abort a ten-cycle op with an exception at T+3
        seen_done = 0;
        mc_start = 1'b1; mc_cycles = 6'd10;
        for (int k = 0; k <= 6; k++) begin
            exc_valid = (k == 3); exc_handler = 32'h00000020;
            cycle();
            mc_start = 1'b0;
            if (s_done) seen_done++;
            chk("abort_flush", {31'h0, s_flush}, (k == 4) ? 32'h1 : 32'h0);
            if (k == 4) chk("abort_pc", s_pc, 32'h00000020);
            if (k == 5) chk("abort_idle", {31'h0, s_busy}, 32'h0);
        end
        chk("abort_no_done", seen_done, 32'h0);
        exc_valid = 1'b0;
        mc_start = 1'b1; mc_cycles = 6'd2;
        for (int k = 0; k <= 3; k++) begin
            cycle();
            mc_start = 1'b0;
            chk("after_abort_done", {31'h0, s_done}, (k == 2) ? 32'h1 : 32'h0);
        end

        // start and exception together, then exception held two cycles
        mc_start = 1'b1; mc_cycles = 6'd3; exc_valid = 1'b1; exc_handler = 32'h00000100;
        cycle();
        mc_start = 1'b0; exc_valid = 1'b0;
        cycle(); chk("simul_flush", {31'h0, s_flush}, 32'h1);
        chk("simul_no_run", {31'h0, s_busy}, 32'h0);
        cycle(); chk("simul_no_run2", {31'h0, s_busy}, 32'h0);
        exc_valid = 1'b1; exc_handler = 32'h00000200; cycle();
        exc_handler = 32'h00000300; cycle();
        chk("hold_flush1", {s_flush, s_pc[30:0]}, 32'h80000200);
        exc_valid = 1'b0; cycle();
        chk("hold_flush2", {s_flush, s_pc[30:0]}, 32'h80000300);
        cycle(); chk("hold_flush_end", {31'h0, s_flush}, 32'h0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            stallreq_id  = ($urandom_range(0, 4) == 0);
            stallreq_mem = ($urandom_range(0, 6) == 0);
            mc_start     = ($urandom_range(0, 5) == 0);
            mc_cycles    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 6));
            exc_valid    = ($urandom_range(0, 39) == 0);
            exc_handler  = $urandom;
            cycle();
        end
        idle_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Generates the per-stage stall vector that freezes the pc, if_id, id_ex, ex_mem and mem_wb registers.
- Sequences multi-cycle EX operations (div, madd/msub) with an internal cycle counter.
- Issues a one-cycle pipeline flush with a redirect PC when an exception is committed from MEM.

Parameters:
- MC_CNT_W, 6, width of the multi-cycle length field and the internal counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_id  in  1  load-use hazard from ID (level)
- stallreq_mem  in  1  data memory not ready (level)
- mc_start  in  1  EX begins a multi-cycle op (single-cycle pulse)
- mc_cycles  in  MC_CNT_W  length N of the op, in cycles
- exc_valid  in  1  exception committed in MEM (level, sampled at posedge)
- exc_handler  in  32  handler address
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold stage register
- flush  out  1  clear all pipeline registers to NOP values
- new_pc  out  32  redirect target, valid while flush=1
- mc_busy  out  1  multi-cycle op in progress
- mc_done  out  1  final cycle of the multi-cycle op (EX result valid)

Behaviour:
- FSM states: IDLE, MC_RUN, FLUSH. Internal counter cnt is MC_CNT_W bits.
- Reset (rst=1 at posedge): state=IDLE, cnt=0, flush=0, new_pc=0, mc_busy=0, mc_done=0, stall=6'b000000. Reset applied mid-operation abandons the op silently; mc_done is not asserted.
- flush and new_pc are registered. stall, mc_busy and mc_done are combinational from state, cnt and the request inputs.
- Stall request encodings:
  - Memory stall: 6'b011111.
  - EX multi-cycle stall: 6'b001111.
  - ID stall: 6'b000111.
- The stall output is the encoding of the highest-priority active request: mem > ex > id. No active request gives 0.
- Exception priority: exc_valid=1 at any posedge outside reset wins over everything else.
  - Next state is FLUSH, new_pc<=exc_handler, cnt<=0.
  - A concurrent mc_start is dropped.
  - A running multi-cycle op is aborted with no mc_done.
- FLUSH state:
  - Lasts exactly one cycle with flush=1 and stall=0. All request inputs are ignored.
  - Next state is IDLE with flush<=0, unless exc_valid is still 1, in which case FLUSH re-enters with the new handler.
- IDLE state:
  - mc_start=1 gives ex-stall in the same cycle.
  - At the posedge: cnt<=max(mc_cycles,1), state<=MC_RUN.
- MC_RUN state:
  - mc_busy=1.
  - While cnt>1: the ex-stall request is active.
  - When cnt==1: mc_done=1 and the ex-stall request is released. The next state is IDLE if stallreq_mem=0.
  - cnt decrements at each posedge while stallreq_mem=0. While stallreq_mem=1, cnt and state hold, mc_done stays asserted if cnt==1, and stall=6'b011111.
  - mc_start while in MC_RUN is ignored.
- Timing: mc_start in cycle T with N>=1 gives stall[3]=1 for cycles T..T+N-1 and mc_done=1 in cycle T+N, absent mem stalls and exceptions.
- mc_cycles=0 is treated as 1: one stall cycle, then mc_done.
- cnt never wraps below 0. Decrement happens only while cnt>=1.
- stallreq_id during MC_RUN is masked by the ex-stall while cnt>1 and honoured on the mc_done cycle.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all requests high -> stall=0, flush=0, new_pc=0, mc_busy=0, mc_done=0; after release, state is IDLE.
- Priority: stallreq_id=1 alone -> stall=6'b000111. Add stallreq_mem=1 -> 6'b011111. Drop both -> 0 in the same cycle.
- Multi-cycle: mc_start with mc_cycles=4 at T -> stall=6'b001111 for T..T+3, mc_done=1 only at T+4, mc_busy=1 for T+1..T+4, then IDLE. Repeat with mc_cycles=0 -> 1 stall cycle, mc_done at T+1.
- Mem stall during op: mc_cycles=3, stallreq_mem=1 for 2 cycles at T+2 -> stall=6'b011111 during those cycles, and mc_done moves from T+3 to T+5.
- Abort: mc_cycles=10, exc_valid=1 with exc_handler=32'h00000020 at T+3 -> flush=1 and new_pc=32'h00000020 at T+4 only, mc_done never asserted, IDLE at T+5; a later mc_start works normally.
- Simultaneous: mc_start and exc_valid at the same posedge -> FLUSH, and no MC_RUN is entered. exc_valid held for 2 cycles -> flush=1 for 2 consecutive cycles.
